// File: rtl/ibex_sm4_pkg.sv
// ibex_sm4_pkg: state encoding, FK/CK constants and the two SM4
// linear transforms shared by the SM4 decryption core.
package ibex_sm4_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEXP,
      S_WAIT,
      S_ROUND,
      S_OUT
   } state_e;

   // FK[0] sits in the top word so a 128-bit key can be XORed directly.
   localparam logic [0:3][31:0] FK = {
      32'hA3B1BAC6,
      32'h56AA3350,
      32'h677D9197,
      32'hB27022DC
   };

   function automatic logic [31:0] rotl(
      input logic [31:0] b,
      input int unsigned n
   );
      return (b << n) | (b >> (32 - n));
   endfunction

   // Byte k of CKj is (4j+k)*7 mod 256, byte 0 in bits [31:24].
   function automatic logic [31:0] ck_word(input logic [4:0] j);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w[31-8*k -: 8] = 8'((4 * int'(j) + k) * 7);
      end
      return w;
   endfunction

   function automatic logic [31:0] l_data(input logic [31:0] b);
      return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
   endfunction

   function automatic logic [31:0] l_key(input logic [31:0] b);
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

endpackage

// File: rtl/ibex_sm4_sbox.sv
// ibex_sm4_sbox: one SM4 byte substitution lane (combinational).
// Ports: x = input byte, y = substituted byte.
module ibex_sm4_sbox
(
   input  logic [7:0] x,
   output logic [7:0] y
);

   localparam logic [0:255][7:0] TBL = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   assign y = TBL[x];

endmodule

// File: rtl/ibex_sm4_dec_core.sv
// ibex_sm4_dec_core: iterative SM4 decryption, key expansion then one
// round per clock. Ports: key_* key handshake, in_* ciphertext in,
// out_* plaintext out, key_ok_o keys ready, busy_o engine active.
module ibex_sm4_dec_core
   import ibex_sm4_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic [127:0] key_i,
   output logic         key_ok_o,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] out_data_o,
   output logic         busy_o
);

   state_e state, state_nx;

   logic [4:0]        cnt;
   logic [3:0][31:0]  win;
   logic [31:0]       rk [32];

   logic        key_hs, in_hs, last, kexp, run;
   logic [31:0] rk_sel, mix, tau, nxt;

   assign kexp = (state == S_KEXP);
   assign run  = kexp || (state == S_ROUND);
   assign last = (cnt == 5'd31);

   assign key_ready_o = (state == S_IDLE) || (state == S_WAIT);
   assign in_ready_o  = (state == S_WAIT) && !key_valid_i;
   assign key_hs      = key_valid_i && key_ready_o;
   assign in_hs       = in_valid_i && in_ready_o;
   assign out_valid_o = (state == S_OUT);
   assign key_ok_o    = (state == S_WAIT) || (state == S_ROUND) ||
                        (state == S_OUT);
   assign busy_o      = run || out_valid_o;

   // win[3] is the oldest word; ~cnt walks the round keys backwards.
   assign rk_sel = kexp ? ck_word(cnt) : rk[~cnt];
   assign mix    = win[2] ^ win[1] ^ win[0] ^ rk_sel;

   for (genvar g = 0; g < 4; g++) begin : g_tau
      ibex_sm4_sbox u_sbox (
         .x (mix[8*g +: 8]),
         .y (tau[8*g +: 8])
      );
   end

   assign nxt = win[3] ^ (kexp ? l_key(tau) : l_data(tau));

   assign out_data_o = out_valid_o ?
                       {win[0], win[1], win[2], win[3]} : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (key_hs) state_nx = S_KEXP;
         S_KEXP:  if (last) state_nx = S_WAIT;
         S_WAIT: begin
            if (key_hs)     state_nx = S_KEXP;
            else if (in_hs) state_nx = S_ROUND;
         end
         S_ROUND: if (last) state_nx = S_OUT;
         S_OUT:   if (out_ready_i) state_nx = S_WAIT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
         win <= '0;
      end else if (key_hs) begin
         cnt <= '0;
         win <= key_i ^ FK;
      end else if (in_hs) begin
         cnt <= '0;
         win <= in_data_i;
      end else if (run) begin
         cnt <= cnt + 5'd1;
         win <= {win[2:0], nxt};
      end
   end

   // Round-key file has no reset; key_ok_o guards its contents.
   always_ff @(posedge clk_i) begin
      if (kexp) rk[cnt] <= nxt;
   end

endmodule

// File: tb/tb_ibex_sm4_dec_core.sv
// tb_ibex_sm4_dec_core: directed and round-trip checks of the SM4
// decryption core against an independent SM4 encryption model.
module tb_ibex_sm4_dec_core;

   logic         clk = 0;
   logic         rst_n = 0;
   logic         key_valid = 0;
   logic         key_ready;
   logic [127:0] key = '0;
   logic         key_ok;
   logic         in_valid = 0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 0;
   logic [127:0] out_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] KEY0 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT0  = 128'h681edf34d206965e86b3e94f536e4246;
   localparam logic [127:0] KEY1 = 128'h00112233445566778899aabbccddeeff;

   localparam logic [0:255][7:0] SB = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   ibex_sm4_dec_core dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .key_valid_i (key_valid),
      .key_ready_o (key_ready),
      .key_i       (key),
      .key_ok_o    (key_ok),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   logic [31:0] mrk [32];

   function automatic logic [31:0] rol(input logic [31:0] a, input int n);
      return (a << n) | (a >> (32 - n));
   endfunction

   function automatic logic [31:0] m_tau(input logic [31:0] a);
      return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
   endfunction

   function automatic logic [31:0] m_t(input logic [31:0] a);
      logic [31:0] b;
      b = m_tau(a);
      return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
   endfunction

   function automatic logic [31:0] m_tk(input logic [31:0] a);
      logic [31:0] b;
      b = m_tau(a);
      return b ^ rol(b, 13) ^ rol(b, 23);
   endfunction

   task automatic m_expand(input logic [127:0] k);
      logic [31:0] kk [36];
      logic [31:0] ck;
      kk[0] = k[127:96] ^ 32'hA3B1BAC6;
      kk[1] = k[95:64]  ^ 32'h56AA3350;
      kk[2] = k[63:32]  ^ 32'h677D9197;
      kk[3] = k[31:0]   ^ 32'hB27022DC;
      for (int i = 0; i < 32; i++) begin
         ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
         kk[i+4] = kk[i] ^ m_tk(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
         mrk[i] = kk[i+4];
      end
   endtask

   function automatic logic [127:0] m_encrypt(input logic [127:0] p);
      logic [31:0] x [36];
      x[0] = p[127:96];
      x[1] = p[95:64];
      x[2] = p[63:32];
      x[3] = p[31:0];
      for (int i = 0; i < 32; i++)
         x[i+4] = x[i] ^ m_t(x[i+1] ^ x[i+2] ^ x[i+3] ^ mrk[i]);
      return {x[35], x[34], x[33], x[32]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [127:0] k, output int lat);
      int n;
      n = 0;
      while (!key_ready && n < 200) begin
         tick();
         n++;
      end
      key = k;
      key_valid = 1;
      #1;
      tick();
      key_valid = 0;
      lat = 1;
      while (!key_ok && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic send_block(input logic [127:0] ct,
                             output logic [127:0] pt, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      in_data = ct;
      in_valid = 1;
      #1;
      tick();
      in_valid = 0;
      wait_out(lat);
      pt = out_data;
      out_ready = 1;
      #1;
      tick();
      out_ready = 0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (key_ready !== 1'b1) begin
         errors++; $display("FAIL reset key_ready got %b want 1", key_ready);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL reset in_ready got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || key_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset flags got ov=%b busy=%b kok=%b want 0 0 0",
                  out_valid, busy, key_ok);
      end
      checks++;
      if (out_data !== '0) begin
         errors++; $display("FAIL reset out_data got %h want 0", out_data);
      end
      @(posedge clk);
      #3 rst_n = 1;
      tick();
   endtask

   task automatic test_data_before_key();
      logic ok;
      int lat;
      logic [127:0] hold;
      in_data = CT0;
      in_valid = 1;
      ok = 1;
      repeat (20) begin
         tick();
         if (in_ready !== 1'b0) ok = 0;
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL nokey in_ready got 1 want 0");
      end
      send_key(KEY0, lat);
      checks++;
      if (lat != 33) begin
         errors++; $display("FAIL key latency got %0d want 33", lat);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL wait in_ready got %b want 1", in_ready);
      end
      tick();
      in_valid = 0;
      wait_out(lat);
      checks++;
      if (lat != 33) begin
         errors++; $display("FAIL data latency got %0d want 33", lat);
      end
      checks++;
      if (out_data !== KEY0) begin
         errors++; $display("FAIL std vector got %h want %h", out_data, KEY0);
      end
      checks++;
      if (in_ready !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL out flags got ir=%b kr=%b busy=%b want 0 0 1",
                  in_ready, key_ready, busy);
      end
      hold = out_data;
      tick();
      tick();
      checks++;
      if (out_data !== hold || out_valid !== 1'b1) begin
         errors++; $display("FAIL out hold got %h want %h", out_data, hold);
      end
      out_ready = 1;
      #1;
      tick();
      out_ready = 0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post out got ir=%b ov=%b busy=%b want 1 0 0",
                  in_ready, out_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] pts [3];
      logic [127:0] ct, hold;
      logic ok;
      int lat;
      pts[0] = 128'h00000000000000000000000000000000;
      pts[1] = 128'hffffffffffffffffffffffffffffffff;
      pts[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      m_expand(KEY0);
      for (int b = 0; b < 3; b++) begin
         ct = m_encrypt(pts[b]);
         in_data = ct;
         in_valid = 1;
         #1;
         tick();
         in_valid = 0;
         wait_out(lat);
         checks++;
         if (lat != 33) begin
            errors++; $display("FAIL b2b%0d latency got %0d want 33", b, lat);
         end
         if (b == 1) begin
            hold = out_data;
            ok = 1;
            repeat (10) begin
               tick();
               if (out_data !== hold || !out_valid || in_ready) ok = 0;
            end
            checks++;
            if (!ok) begin
               errors++; $display("FAIL stall got %h want %h", out_data, hold);
            end
         end
         checks++;
         if (out_data !== pts[b]) begin
            errors++;
            $display("FAIL b2b%0d data got %h want %h", b, out_data, pts[b]);
         end
         out_ready = 1;
         #1;
         tick();
         out_ready = 0;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b%0d ready got %b want 1", b, in_ready);
         end
      end
   endtask

   task automatic test_key_priority();
      logic [127:0] pt, ct;
      logic ok;
      int lat;
      m_expand(KEY1);
      pt = 128'hdeadbeef0badf00dcafebabe12345678;
      ct = m_encrypt(pt);
      key = KEY1;
      key_valid = 1;
      in_data = ct;
      in_valid = 1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || key_ready !== 1'b1) begin
         errors++;
         $display("FAIL prio ready got ir=%b kr=%b want 0 1",
                  in_ready, key_ready);
      end
      tick();
      key_valid = 0;
      ok = 1;
      for (int n = 1; n <= 32; n++) begin
         if (key_ok !== 1'b0 || in_ready !== 1'b0) ok = 0;
         tick();
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL prio kexp window got early ok/ready");
      end
      checks++;
      if (key_ok !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL prio done got kok=%b ir=%b want 1 1", key_ok, in_ready);
      end
      tick();
      in_valid = 0;
      wait_out(lat);
      checks++;
      if (out_data !== pt || lat != 33) begin
         errors++;
         $display("FAIL prio data got %h lat %0d want %h lat 33",
                  out_data, lat, pt);
      end
      out_ready = 1;
      #1;
      tick();
      out_ready = 0;
   endtask

   task automatic test_async_reset();
      in_data = 128'h1;
      in_valid = 1;
      #1;
      tick();
      in_valid = 0;
      repeat (10) tick();
      #2 rst_n = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || key_ok !== 1'b0 ||
          key_ready !== 1'b1 || in_ready !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL arst got busy=%b ov=%b kok=%b kr=%b ir=%b want 0 0 0 1 0",
                  busy, out_valid, key_ok, key_ready, in_ready);
      end
      @(posedge clk);
      #3 rst_n = 1;
      tick();
      in_valid = 1;
      #1;
      checks++;
      if (key_ok !== 1'b0 || key_ready !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL arst release got kok=%b kr=%b ir=%b want 0 1 0",
                  key_ok, key_ready, in_ready);
      end
      in_valid = 0;
   endtask

   task automatic test_random();
      logic [127:0] k, pt, ct, got;
      int lat;
      for (int i = 0; i < 50; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         m_expand(k);
         send_key(k, lat);
         checks++;
         if (lat != 33) begin
            errors++; $display("FAIL rand key%0d latency got %0d want 33", i, lat);
         end
         for (int b = 0; b < 20; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = m_encrypt(pt);
            send_block(ct, got, lat);
            checks++;
            if (got !== pt || lat != 33) begin
               errors++;
               $display("FAIL rand k%0d b%0d got %h lat %0d want %h",
                        i, b, got, lat, pt);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_data_before_key();
      test_back_to_back();
      test_key_priority();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ibex_sm4_dec_core.md
# ibex_sm4_dec_core

Iterative SM4 block-decryption engine: expands a 128-bit key into 32 round keys, then inverts ciphertext blocks one round per clock using the round keys in reverse order. Sits beside the SM4 S-box datapath in the core's crypto extension and is the receive side of the SM4 encrypt path. The four S-box lanes (tau) are shared between key expansion and data rounds, which never run concurrently.

## Interface
- Parameters: none.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- key_valid_i  in  1  key offer.
- key_ready_o  out  1  key acceptance.
- key_i  in  128  master key; [127:96]=MK0 … [31:0]=MK3.
- key_ok_o  out  1  round-key file holds a completed expansion.
- in_valid_i  in  1  ciphertext offer.
- in_ready_o  out  1  ciphertext acceptance.
- in_data_i  in  128  ciphertext; [127:96]=X0 … [31:0]=X3.
- out_valid_o  out  1  plaintext available.
- out_ready_i  in  1  consumer acceptance.
- out_data_o  out  128  plaintext {X35,X34,X33,X32}.
- busy_o  out  1  high in KEXP, ROUND and OUT.

## Operation
- States: IDLE (no keys), KEXP, WAIT (keys valid), ROUND, OUT.
- IDLE: key_ready_o=1, in_ready_o=0. A key handshake loads K0..K3 = MK0..MK3 ^ FK0..FK3, clears the 5-bit round counter, and moves to KEXP.
- KEXP: each cycle rk[j] = K(j+4) = Kj ^ L'(tau(K(j+1)^K(j+2)^K(j+3)^CKj)). The K window shifts left one word. L'(B)=B^(B<<<13)^(B<<<23). After j=31 move to WAIT and set key_ok_o.
- WAIT: key_ready_o=1. in_ready_o = ~key_valid_i, so a new key has priority over data.
  - A key handshake clears key_ok_o and restarts KEXP.
  - A data handshake loads X0..X3 and moves to ROUND.
- ROUND: round i (0..31) computes X(i+4) = Xi ^ L(tau(X(i+1)^X(i+2)^X(i+3)^rk[31-i])). L(B)=B^(B<<<2)^(B<<<10)^(B<<<18)^(B<<<24). After i=31 move to OUT.
- OUT: out_valid_o=1 and out_data_o holds word-reversed state, stable until out_ready_i. On the handshake return to WAIT.
- tau: four parallel byte S-boxes on a 32-bit word. A mux selects L or L' and the round-key or CK input according to state.
- Round counter wraps only via explicit clear. Terminal count 31 is checked in both KEXP and ROUND.
- Reset values: state IDLE, key_ok_o=0, key_ready_o=1, in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0. The round-key file is not reset and is guarded by key_ok_o.
- Reset asserted mid-KEXP or mid-ROUND aborts the operation. Key material is invalidated and a new key is required.

## Timing
- Key handshake in cycle c: KEXP occupies c+1..c+32, key_ok_o=1 from c+33.
- Data handshake in cycle c: rounds occupy c+1..c+32, out_valid_o=1 from c+33 (33-cycle latency).
- Output handshake in cycle d: in_ready_o=1 in d+1 at the earliest (no bypass). Peak throughput is one block per 34 cycles.
- key_ready_o and in_ready_o are 0 in KEXP, ROUND and OUT. Offers are held off, never dropped.
- No combinational path from out_ready_i to in_ready_o.
- key_valid_i to in_ready_o is the only valid-to-ready path.

## Structure
- ibex_sm4_pkg holds:
  - FK[0:3] = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - The CK table: byte k of CKj = (4j+k)·7 mod 256.
  - The state enum.
  - L and L' as functions.
- Sub-module ibex_sm4_sbox, instantiated four times for tau.
- Remaining logic stays flat: FSM, counter, 128-bit shift window, 32×32 rk file.

## Test plan
- Key and ciphertext vectors:
  - Key 0123456789ABCDEFFEDCBA9876543210, ciphertext 681EDF34D206965E86B3E94F536E4246 -> out_data_o = 0123456789ABCDEFFEDCBA9876543210, exactly 33 cycles after the in-handshake.
- Data before key:
  - in_valid_i=1 from reset with no key -> in_ready_o stays 0.
  - Key given -> key_ok_o rises 33 cycles after the key handshake, then data is accepted.
- Back-to-back with stall:
  - 3 blocks, out_ready_i held low 10 cycles on block 2 -> out_data_o stable throughout, in_ready_o=0 while stalled.
  - All 3 plaintexts match a reference model.
- Simultaneous key and data in WAIT:
  - key_valid_i=in_valid_i=1 -> key accepted, data not accepted, key_ok_o=0 for 32 cycles.
  - The following block decrypts with the new key.
- Asynchronous reset mid-operation:
  - rst_ni low during round 10 -> outputs at reset values immediately; after release key_ok_o=0, key_ready_o=1.
- Randomized round-trip:
  - 1000 random key/plaintext pairs encrypted by the model and fed in -> every output equals its plaintext.
